// File: rtl/prince_mask_pkg.sv
// Shared constants and share-slice helpers for the masked PRINCE datapath.
package prince_mask_pkg;

    localparam int DEF_WIDTH  = 64;
    localparam int DEF_SHARES = 5;

    // LSB position of share s inside a packed SHARES*WIDTH word.
    function automatic int share_lsb(input int s, input int width);
        return s * width;
    endfunction

endpackage

// File: rtl/masked_share_slot.sv
// One pipeline slot: a valid bit plus SHARES independent per-share data registers.
module masked_share_slot
    import prince_mask_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SHARES    = DEF_SHARES,
    parameter int ZERO_IDLE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    i_load,
    input  logic                    i_valid,
    input  logic [SHARES*WIDTH-1:0] i_data,
    output logic                    o_valid,
    output logic [SHARES*WIDTH-1:0] o_data
);

    logic r_valid;

    always_ff @(posedge clk) begin
        if (rst)
            r_valid <= 1'b0;
        else if (flush)
            r_valid <= 1'b0;
        else if (i_load)
            r_valid <= i_valid;
    end

    assign o_valid = r_valid;

    // Each share gets its own register so no logic ever spans two shares.
    for (genvar s = 0; s < SHARES; s++) begin : g_share
        localparam int LSB = share_lsb(s, WIDTH);
        logic [WIDTH-1:0] r_share;

        always_ff @(posedge clk) begin
            if (rst)
                r_share <= '0;
            else if (flush) begin
                if (ZERO_IDLE != 0)
                    r_share <= '0;
            end else if (i_load)
                r_share <= (ZERO_IDLE != 0 && !i_valid) ? '0 : i_data[LSB +: WIDTH];
        end

        assign o_data[LSB +: WIDTH] = r_share;
    end

endmodule

// File: rtl/masked_share_pipeline.sv
// Elastic share-domain register pipeline with bubble collapsing, flush and occupancy.
module masked_share_pipeline
    import prince_mask_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SHARES    = DEF_SHARES,
    parameter int DEPTH     = 2,
    parameter int ZERO_IDLE = 1,
    localparam int OCC_W    = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SHARES*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SHARES*WIDTH-1:0] out_data,
    output logic [OCC_W-1:0]        occupancy
);

    // Chain index 0 is the upstream input; index i+1 is the output of slot i.
    logic [DEPTH:0]                   w_vc;
    logic [DEPTH:0][SHARES*WIDTH-1:0] w_dc;
    logic [DEPTH:0]                   w_adv;
    logic [OCC_W-1:0]                 w_occ;

    assign w_vc[0] = in_valid;
    assign w_dc[0] = in_data;

    // A slot advances if anything downstream of it (inclusive) is empty or the sink takes data.
    always_comb begin
        w_adv        = '0;
        w_adv[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--)
            w_adv[i] = w_adv[i+1] | ~w_vc[i+1];
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        masked_share_slot #(
            .WIDTH     (WIDTH),
            .SHARES    (SHARES),
            .ZERO_IDLE (ZERO_IDLE)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .i_load  (w_adv[i]),
            .i_valid (w_vc[i]),
            .i_data  (w_dc[i]),
            .o_valid (w_vc[i+1]),
            .o_data  (w_dc[i+1])
        );
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++)
            w_occ = w_occ + OCC_W'(w_vc[i+1]);
    end

    assign in_ready  = w_adv[0];
    assign out_valid = w_vc[DEPTH];
    assign out_data  = w_dc[DEPTH];
    assign occupancy = w_occ;

endmodule
